// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath definitions: widths, the canonical NOP and the
// IF/ID pipeline register layout used by fetch and decode.
package riscv_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [31:0]     inst;
    } ifid_t;

    // Bubble contents written on reset and on a redirect squash.
    function automatic ifid_t ifid_bubble();
        ifid_t b;
        b.valid    = 1'b0;
        b.pc       = '0;
        b.pc_plus4 = '0;
        b.inst     = NOP_INST;
        return b;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: reset load, hold on stall, word-aligned redirect
// (which beats stall) and sequential +4 advance with natural wrap.
module pc_reg #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
);

    logic [XLEN-1:0] pc_q;

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + XLEN'(4);

    // PC update: reset, then redirect, then stall hold, otherwise advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            // Low bits are dropped; misalignment is reported by the fetch stage.
            pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (!stall) begin
            pc_q <= pc_plus4;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: drives the PC to the asynchronous IMEM and
// captures the returned word with its PC into the IF/ID register.
// XLEN must match riscv_pkg::XLEN because the IF/ID layout is shared.
module if_stage #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_pc,
    input  logic [31:0]     imem_inst,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_pc_plus4,
    output logic [31:0]     ifid_inst,
    output logic            fetch_misalign
);

    import riscv_pkg::*;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_plus4;
    ifid_t           ifid_q;
    logic            misalign_q;

    pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc_q),
        .pc_plus4       (pc_plus4)
    );

    assign imem_pc = pc_q;

    // IF/ID register: squash on redirect, hold on stall, else capture fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_q <= ifid_bubble();
        end else if (redirect_valid) begin
            ifid_q <= ifid_bubble();
        end else if (!stall) begin
            ifid_q.valid    <= 1'b1;
            ifid_q.pc       <= pc_q;
            ifid_q.pc_plus4 <= pc_plus4;
            ifid_q.inst     <= imem_inst;
        end
    end

    // Misalign flag is a single-cycle pulse following a redirect edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (redirect_valid) begin
            misalign_q <= |redirect_pc[1:0];
        end else begin
            misalign_q <= 1'b0;
        end
    end

    assign ifid_valid     = ifid_q.valid;
    assign ifid_pc        = ifid_q.pc;
    assign ifid_pc_plus4  = ifid_q.pc_plus4;
    assign ifid_inst      = ifid_q.inst;
    assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage. IMEM is modelled as word[i] = i.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_pc;
    logic [31:0] imem_inst;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic [31:0] ifid_inst;
    logic        fetch_misalign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_inst = {2'b00, imem_pc[31:2]};

    if_stage #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_pc        (imem_pc),
        .imem_inst      (imem_inst),
        .ifid_valid     (ifid_valid),
        .ifid_pc        (ifid_pc),
        .ifid_pc_plus4  (ifid_pc_plus4),
        .ifid_inst      (ifid_inst),
        .fetch_misalign (fetch_misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        step(); step();
        chk("rst_imem_pc", imem_pc, 32'h0);
        chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
        chk("rst_inst", ifid_inst, 32'h13);
        chk("rst_pc", ifid_pc, 32'h0);
        chk("rst_misalign", {31'b0, fetch_misalign}, 32'h0);

        rst = 1'b0;
        step();
        chk("run1_pc", ifid_pc, 32'h0);
        chk("run1_inst", ifid_inst, 32'h0);
        chk("run1_valid", {31'b0, ifid_valid}, 32'h1);
        chk("run1_imem_pc", imem_pc, 32'h4);
        step(); step();
        chk("run3_pc", ifid_pc, 32'h8);
        chk("run3_pc4", ifid_pc_plus4, 32'hC);
        chk("run3_inst", ifid_inst, 32'h2);
        step();
        chk("run4_imem_pc", imem_pc, 32'h10);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_imem_pc", imem_pc, 32'h10);
            chk("stall_ifid_pc", ifid_pc, 32'hC);
            chk("stall_valid", {31'b0, ifid_valid}, 32'h1);
        end
        stall = 1'b0;
        step();
        chk("unstall_pc", ifid_pc, 32'h10);
        chk("unstall_imem_pc", imem_pc, 32'h14);

        redirect_valid = 1'b1; redirect_pc = 32'h8;
        step();
        chk("redir8_imem_pc", imem_pc, 32'h8);
        redirect_pc = 32'h40;
        step();
        chk("redir_valid", {31'b0, ifid_valid}, 32'h0);
        chk("redir_inst", ifid_inst, 32'h13);
        chk("redir_imem_pc", imem_pc, 32'h40);
        redirect_valid = 1'b0;
        step();
        chk("tgt_pc", ifid_pc, 32'h40);
        chk("tgt_pc4", ifid_pc_plus4, 32'h44);
        chk("tgt_inst", ifid_inst, 32'h10);
        chk("tgt_valid", {31'b0, ifid_valid}, 32'h1);

        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        chk("rs_imem_pc", imem_pc, 32'h100);
        chk("rs_valid", {31'b0, ifid_valid}, 32'h0);
        chk("rs_inst", ifid_inst, 32'h13);
        chk("rs_pc", ifid_pc, 32'h0);
        redirect_valid = 1'b0;
        step();
        chk("rs_hold_imem_pc", imem_pc, 32'h100);
        chk("rs_hold_valid", {31'b0, ifid_valid}, 32'h0);
        stall = 1'b0;
        step();
        chk("rs_tgt_pc", ifid_pc, 32'h100);
        chk("rs_tgt_inst", ifid_inst, 32'h40);

        redirect_valid = 1'b1; redirect_pc = 32'h46;
        step();
        chk("mis_imem_pc", imem_pc, 32'h44);
        chk("mis_flag", {31'b0, fetch_misalign}, 32'h1);
        redirect_valid = 1'b0;
        step();
        chk("mis_pulse_end", {31'b0, fetch_misalign}, 32'h0);
        chk("mis_tgt_pc", ifid_pc, 32'h44);
        chk("mis_tgt_inst", ifid_inst, 32'h11);

        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        chk("wrap_imem_pc0", imem_pc, 32'hFFFF_FFFC);
        chk("wrap_misalign", {31'b0, fetch_misalign}, 32'h0);
        redirect_valid = 1'b0;
        step();
        chk("wrap_imem_pc", imem_pc, 32'h0);
        chk("wrap_ifid_pc", ifid_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", ifid_pc_plus4, 32'h0);
        chk("wrap_inst", ifid_inst, 32'h3FFF_FFFF);

        redirect_valid = 1'b1; redirect_pc = 32'h20;
        step();
        chk("pre_rst_imem_pc", imem_pc, 32'h20);
        rst = 1'b1; stall = 1'b1; redirect_pc = 32'h81;
        step();
        chk("mrst_imem_pc", imem_pc, 32'h0);
        chk("mrst_valid", {31'b0, ifid_valid}, 32'h0);
        chk("mrst_inst", ifid_inst, 32'h13);
        chk("mrst_misalign", {31'b0, fetch_misalign}, 32'h0);
        rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        step();
        chk("post_rst_pc", ifid_pc, 32'h0);
        chk("post_rst_valid", {31'b0, ifid_valid}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
